alu_cmd_sequencer: RTL

- Upstream command stage for little_alu.
- Accepts ALU commands on a valid/ready interface and buffers them in a small FIFO.
- Issues one command at a time to the ALU (start_op/op_sel/A/B), waits for end_op, and returns the captured 32-bit result, tagged with a status, on a valid/ready response interface.
- Guards against a hung ALU with a cycle timeout.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_cmd_fifo.sv | 63 ++++++
 rtl/alu_cmd_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: opcodes, response status,
// command record and the legal-opcode check.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_XOR = 4'd3,
        OP_MUL = 4'd4,
        OP_AND = 4'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_TIMEOUT = 2'b01,
        ST_ILLEGAL = 2'b10
    } status_e;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
    } alu_cmd_t;

    // Codes above OP_AND (including the ALU display codes) are never driven.
    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= OP_AND;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: power-of-2 depth, wrapping pointers plus an occupancy count.
// ready is registered from the next count, so a pop never frees a slot early.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset_p,
    input  logic     push,
    input  logic     pop,
    input  alu_cmd_t wdata,
    output alu_cmd_t rdata,
    output logic     empty,
    output logic     ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    alu_cmd_t       mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic [AW:0]    count_next;
    logic           do_push;
    logic           do_pop;

    assign do_push = push && ready;
    assign do_pop  = pop && (count != '0);
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop)
            count_next = count + (AW+1)'(1);
        else if (!do_push && do_pop)
            count_next = count - (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            ready <= (count_next != FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Upstream command stage for little_alu: queues commands, issues them one at a
// time, waits for end_op (with a timeout) and returns a tagged response.
//
// state   | meaning
// IDLE    | waiting for a queued command; pops it when one is present
// ISSUE   | start_op high, op_sel/A/B stable, timeout down-counter running
// RESP    | rsp_valid high, response held until rsp_ready
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic        start_op,
    output logic [3:0]  op_sel,
    output logic [15:0] A,
    output logic [15:0] B,
    input  logic        end_op,
    input  logic [31:0] result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_op,
    output logic [1:0]  rsp_status,
    output logic        busy
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    state_e        state;
    logic [CW-1:0] tmr;
    alu_cmd_t      cmd_in;
    alu_cmd_t      head;
    logic          fifo_empty;
    logic          pop;

    assign cmd_in = '{op: cmd_op, a: cmd_a, b: cmd_b};
    assign pop    = (state == S_IDLE) && !fifo_empty;
    assign busy   = (state != S_IDLE) || !fifo_empty;

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_p (reset_p),
        .push    (cmd_valid),
        .pop     (pop),
        .wdata   (cmd_in),
        .rdata   (head),
        .empty   (fifo_empty),
        .ready   (cmd_ready)
    );

    // Timer counts down from TIMEOUT-1; reaching zero without end_op aborts.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state      <= S_IDLE;
            tmr        <= '0;
            start_op   <= 1'b0;
            op_sel     <= '0;
            A          <= '0;
            B          <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_op     <= '0;
            rsp_status <= ST_OK;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        if (is_legal_op(head.op) && head.op != OP_NOP) begin
                            op_sel   <= head.op;
                            A        <= head.a;
                            B        <= head.b;
                            tmr      <= CW'(TIMEOUT - 1);
                            start_op <= 1'b1;
                            state    <= S_ISSUE;
                        end else begin
                            rsp_data   <= '0;
                            rsp_op     <= head.op;
                            rsp_status <= is_legal_op(head.op) ? ST_OK : ST_ILLEGAL;
                            rsp_valid  <= 1'b1;
                            state      <= S_RESP;
                        end
                    end
                end
                S_ISSUE: begin
                    if (end_op) begin
                        rsp_data   <= result;
                        rsp_op     <= op_sel;
                        rsp_status <= ST_OK;
                        start_op   <= 1'b0;
                        rsp_valid  <= 1'b1;
                        state      <= S_RESP;
                    end else if (tmr == '0) begin
                        rsp_data   <= '0;
                        rsp_op     <= op_sel;
                        rsp_status <= ST_TIMEOUT;
                        start_op   <= 1'b0;
                        rsp_valid  <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        tmr <= tmr - CW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
